// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: pixel-enable divider and horizontal/vertical scan timing
// for the Pong VGA datapath. Everything runs on clk_in, and pix_en is a clock
// enable, not a derived clock.
// Optional feature: define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
// hsync, vsync, video_on and the ticks are registered from the next-count
// values. This keeps them in the same cycle as pixel_x/pixel_y.
// Porch and sync widths are assumed to be at least 1, and H_TOTAL/V_TOTAL
// are assumed to be at most 1024.
module vga_timing_ctrl #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit SYNC_ACT  = 1'b0
) (
   input  logic       clk_in,
   input  logic       rst,
   output logic       pix_en,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       line_tick,
   output logic       frame_tick
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [7:0] frame_cnt
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_FP_START = 10'(H_VISIBLE);
   localparam logic [9:0] H_SY_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] H_BP_START = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_FP_START = 10'(V_VISIBLE);
   localparam logic [9:0] V_SY_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] V_BP_START = 10'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {HS_ACTIVE, HS_FRONT, HS_SYNC, HS_BACK} h_state_t;
   typedef enum logic [1:0] {VS_ACTIVE, VS_FRONT, VS_SYNC, VS_BACK} v_state_t;

   logic [DIV_W-1:0] div_cnt;
   logic             div_wrap;
   logic [9:0]       x_next;
   logic [9:0]       y_next;
   h_state_t         h_state;
   h_state_t         h_state_next;
   v_state_t         v_state;
   v_state_t         v_state_next;
   logic             hsync_next;
   logic             vsync_next;
   logic             video_on_next;
   logic             line_tick_next;
   logic             frame_tick_next;

   // pix_en is raised on the cycle after div_cnt reaches CLK_DIV-1.
   // With CLK_DIV=1 that condition always holds, so pix_en stays high.
   assign div_wrap = (div_cnt == DIV_LAST);

   // Pixel-rate divider: count 0..CLK_DIV-1 and wrap.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (div_wrap) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Next scan position. The counters move only when the current cycle has pix_en.
   always_comb begin
      x_next = pixel_x;
      y_next = pixel_y;
      if (pix_en) begin
         if (pixel_x == H_LAST) begin
            x_next = '0;
            y_next = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
         end else begin
            x_next = pixel_x + 10'd1;
         end
      end
   end

   // FSM state register for the horizontal and vertical scan regions.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         h_state <= HS_ACTIVE;
         v_state <= VS_ACTIVE;
      end else begin
         h_state <= h_state_next;
         v_state <= v_state_next;
      end
   end

   // FSM next state: step region when the upcoming count crosses a boundary.
   // y_next changes only at a line wrap, so the vertical FSM steps per line.
   always_comb begin
      h_state_next = h_state;
      unique case (h_state)
         HS_ACTIVE: if (x_next == H_FP_START) h_state_next = HS_FRONT;
         HS_FRONT:  if (x_next == H_SY_START) h_state_next = HS_SYNC;
         HS_SYNC:   if (x_next == H_BP_START) h_state_next = HS_BACK;
         HS_BACK:   if (x_next == 10'd0)      h_state_next = HS_ACTIVE;
         default:   h_state_next = HS_ACTIVE;
      endcase
      v_state_next = v_state;
      unique case (v_state)
         VS_ACTIVE: if (y_next == V_FP_START) v_state_next = VS_FRONT;
         VS_FRONT:  if (y_next == V_SY_START) v_state_next = VS_SYNC;
         VS_SYNC:   if (y_next == V_BP_START) v_state_next = VS_BACK;
         VS_BACK:   if (y_next == 10'd0)      v_state_next = VS_ACTIVE;
         default:   v_state_next = VS_ACTIVE;
      endcase
   end

   // FSM outputs, decoded from the next state so they register in step with the counters.
   always_comb begin
      hsync_next      = (h_state_next == HS_SYNC) ? SYNC_ACT : ~SYNC_ACT;
      vsync_next      = (v_state_next == VS_SYNC) ? SYNC_ACT : ~SYNC_ACT;
      video_on_next   = (h_state_next == HS_ACTIVE) && (v_state_next == VS_ACTIVE);
      line_tick_next  = div_wrap && (x_next == H_LAST);
      frame_tick_next = line_tick_next && (y_next == V_LAST);
   end

   // Output registers. Reset puts every output in its idle state at once.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         pix_en     <= 1'b0;
         pixel_x    <= '0;
         pixel_y    <= '0;
         video_on   <= 1'b0;
         hsync      <= ~SYNC_ACT;
         vsync      <= ~SYNC_ACT;
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         pix_en     <= div_wrap;
         pixel_x    <= x_next;
         pixel_y    <= y_next;
         video_on   <= video_on_next;
         hsync      <= hsync_next;
         vsync      <= vsync_next;
         line_tick  <= line_tick_next;
         frame_tick <= frame_tick_next;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   // Frame counter used for game speed pacing. It counts frame_tick pulses and wraps at 255.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (frame_tick) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed bench with two instances.
// The first uses default 640x480 timing and covers reset release and line timing.
// The second uses a reduced 12x8 raster with active-high sync, so whole frames,
// visibility corners and a mid-frame reset fit in a short run.
module tb_vga_timing_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default-geometry instance (d_*).
   logic       rst_d;
   logic       d_pix_en, d_vo, d_hs, d_vs, d_lt, d_ft;
   logic [9:0] d_x, d_y;
   // Small-geometry instance (s_*): H 6/2/2/2 = 12, V 4/1/2/1 = 8, SYNC_ACT=1.
   logic       rst_s;
   logic       s_pix_en, s_vo, s_hs, s_vs, s_lt, s_ft;
   logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0] d_fc, s_fc;
`endif

   vga_timing_ctrl u_dut_d (
      .clk_in(clk), .rst(rst_d), .pix_en(d_pix_en), .pixel_x(d_x), .pixel_y(d_y),
      .video_on(d_vo), .hsync(d_hs), .vsync(d_vs), .line_tick(d_lt), .frame_tick(d_ft)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(d_fc)
`endif
   );

   vga_timing_ctrl #(
      .CLK_DIV(2), .H_VISIBLE(6), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACT(1'b1)
   ) u_dut_s (
      .clk_in(clk), .rst(rst_s), .pix_en(s_pix_en), .pixel_x(s_x), .pixel_y(s_y),
      .video_on(s_vo), .hsync(s_hs), .vsync(s_vs), .line_tick(s_lt), .frame_tick(s_ft)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(s_fc)
`endif
   );

   // Monitor mux so the table loop can address either instance.
   bit         msel;
   logic       m_pix_en, m_vo, m_hs, m_vs, m_lt, m_ft;
   logic [9:0] m_x, m_y;
   assign m_pix_en = msel ? s_pix_en : d_pix_en;
   assign m_vo     = msel ? s_vo : d_vo;
   assign m_hs     = msel ? s_hs : d_hs;
   assign m_vs     = msel ? s_vs : d_vs;
   assign m_lt     = msel ? s_lt : d_lt;
   assign m_ft     = msel ? s_ft : d_ft;
   assign m_x      = msel ? s_x : d_x;
   assign m_y      = msel ? s_y : d_y;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Wait, with a cycle budget, for a pix_en cycle at (x,y) on the selected instance.
   task automatic wait_at(input bit sel, input int x, input int y, output bit ok);
      msel = sel;
      ok   = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (m_pix_en === 1'b1 && m_x == 10'(x) && m_y == 10'(y)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Wait, with a cycle budget, for a frame_tick on the small instance.
   task automatic wait_ft(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (s_ft === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      bit sel;
      int x;
      int y;
      bit vo;
      bit hs;
      bit vs;
      bit lt;
      bit ft;
   } vec_t;

   vec_t vecs[$];

   initial begin
      bit ok;
      int cyc, vs_err, ft_err, lt_cycles, vs_cycles;

      // Records: {instance, x, y, video_on, hsync, vsync, line_tick, frame_tick}.
      // Default instance: active-low sync, hsync low for x = 656..751.
      vecs.push_back('{1'b0, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 799, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0,   0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      // Small instance: active-high sync, hsync for x = 8..9, vsync for y = 5..6.
      vecs.push_back('{1'b1,  0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1,  5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1,  6, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1,  7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1,  8, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1,  9, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 10, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 11, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1,  5, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1,  0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 11, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1,  0, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1,  8, 6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1,  0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 11, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1,  0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

      // Reset state on both instances.
      rst_d = 1'b1;
      rst_s = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst d pix_en", 32'(d_pix_en), 0);
      chk("rst d pixel_x", 32'(d_x), 0);
      chk("rst d pixel_y", 32'(d_y), 0);
      chk("rst d video_on", 32'(d_vo), 0);
      chk("rst d hsync", 32'(d_hs), 1);
      chk("rst d vsync", 32'(d_vs), 1);
      chk("rst d line_tick", 32'(d_lt), 0);
      chk("rst d frame_tick", 32'(d_ft), 0);
      chk("rst s hsync", 32'(s_hs), 0);
      chk("rst s vsync", 32'(s_vs), 0);
      chk("rst s pix_en", 32'(s_pix_en), 0);
      chk("rst s video_on", 32'(s_vo), 0);

      // Reset release with CLK_DIV=2: pix_en is low, then high every second cycle.
      rst_d = 1'b0;
      @(negedge clk);
      chk("rel c1 pix_en", 32'(d_pix_en), 0);
      chk("rel c1 pixel_x", 32'(d_x), 0);
      chk("rel c1 video_on", 32'(d_vo), 1);
      @(negedge clk);
      chk("rel c2 pix_en", 32'(d_pix_en), 1);
      chk("rel c2 pixel_x", 32'(d_x), 0);
      @(negedge clk);
      chk("rel c3 pix_en", 32'(d_pix_en), 0);
      chk("rel c3 pixel_x", 32'(d_x), 1);
      @(negedge clk);
      chk("rel c4 pix_en", 32'(d_pix_en), 1);
      chk("rel c4 pixel_x", 32'(d_x), 1);
      @(negedge clk);
      chk("rel c5 pixel_x", 32'(d_x), 2);

      // Table-driven positional checks.
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].sel && rst_s) rst_s = 1'b0;
         wait_at(vecs[i].sel, vecs[i].x, vecs[i].y, ok);
         chk($sformatf("vec%0d (%0d,%0d) reached", i, vecs[i].x, vecs[i].y), 32'(ok), 1);
         if (ok) begin
            chk($sformatf("vec%0d video_on", i), 32'(m_vo), 32'(vecs[i].vo));
            chk($sformatf("vec%0d hsync", i), 32'(m_hs), 32'(vecs[i].hs));
            chk($sformatf("vec%0d vsync", i), 32'(m_vs), 32'(vecs[i].vs));
            chk($sformatf("vec%0d line_tick", i), 32'(m_lt), 32'(vecs[i].lt));
            chk($sformatf("vec%0d frame_tick", i), 32'(m_ft), 32'(vecs[i].ft));
         end
      end

      // line_tick lasts one cycle and is followed by x=0 and y+1.
      wait_at(1'b0, 799, 1, ok);
      chk("d (799,1) reached", 32'(ok), 1);
      @(negedge clk);
      chk("after line_tick lt", 32'(d_lt), 0);
      chk("after line_tick pix_en", 32'(d_pix_en), 0);
      chk("after line_tick x", 32'(d_x), 0);
      chk("after line_tick y", 32'(d_y), 2);

      // One full small frame between two frame_ticks: 96 pixels * 2 = 192 cycles.
      wait_ft(ok);
      chk("s first frame_tick", 32'(ok), 1);
      cyc = 0; vs_err = 0; ft_err = 0; lt_cycles = 0; vs_cycles = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (s_lt) lt_cycles++;
         if (s_vs) vs_cycles++;
         if (s_ft && !(s_lt && s_pix_en)) ft_err++;
         if (s_lt && !s_pix_en) ft_err++;
         if (s_pix_en && (s_vs !== ((s_y == 10'd5) || (s_y == 10'd6)))) vs_err++;
      end while (!s_ft && cyc < 400);
      chk("frame period cycles", 32'(cyc), 192);
      chk("line_tick cycles per frame", 32'(lt_cycles), 8);
      chk("vsync active cycles", 32'(vs_cycles), 48);
      chk("vsync rows 5..6 errors", 32'(vs_err), 0);
      chk("tick qualification errors", 32'(ft_err), 0);

      // Mid-frame asynchronous reset: outputs return to idle without a clock edge.
      wait_at(1'b1, 3, 5, ok);
      chk("s (3,5) reached", 32'(ok), 1);
      #1 rst_s = 1'b1;
      #1;
      chk("midrst pix_en", 32'(s_pix_en), 0);
      chk("midrst pixel_x", 32'(s_x), 0);
      chk("midrst pixel_y", 32'(s_y), 0);
      chk("midrst vsync", 32'(s_vs), 0);
      chk("midrst video_on", 32'(s_vo), 0);
      @(negedge clk);
      rst_s = 1'b0;
      @(negedge clk);
      chk("midrst rel c1 pix_en", 32'(s_pix_en), 0);
      chk("midrst rel c1 y", 32'(s_y), 0);
      @(negedge clk);
      chk("midrst rel c2 pix_en", 32'(s_pix_en), 1);
      chk("midrst rel c2 x", 32'(s_x), 0);
      @(negedge clk);
      chk("midrst rel c3 x", 32'(s_x), 1);
      chk("midrst rel c3 y", 32'(s_y), 0);

`ifdef VGA_FRAME_CNT_EN
      // Frame counter: 0 after reset, 3 after three frames, 0 again after 256 frames.
      chk("frame_cnt after reset", 32'(s_fc), 0);
      for (int k = 0; k < 3; k++) begin
         wait_ft(ok);
         chk($sformatf("frame_tick %0d seen", k), 32'(ok), 1);
      end
      @(negedge clk);
      chk("frame_cnt after 3", 32'(s_fc), 3);
      for (int k = 3; k < 256; k++) begin
         wait_ft(ok);
         if (!ok) begin
            chk($sformatf("frame_tick %0d seen", k), 32'(ok), 1);
            break;
         end
      end
      @(negedge clk);
      chk("frame_cnt after 256", 32'(s_fc), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
